// File: rtl/sm_key_debouncer_pkg.sv
// Shared key-input definitions: pin polarity constants, counter width helper,
// auto-repeat phase encoding. Imported by sm_key_channel and sm_key_debouncer.
package sm_key_debouncer_pkg;

  localparam int unsigned POL_ACTIVE_HIGH = 0;
  localparam int unsigned POL_ACTIVE_LOW  = 1;

  typedef enum logic {
    REP_DELAY  = 1'b0,
    REP_PERIOD = 1'b1
  } rep_phase_e;

  // Bits needed to hold a count of 0..n-1 with one bit of headroom
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // Pin level seen while the key is not pressed
  function automatic logic idle_level(input int unsigned active_low);
    return (active_low != POL_ACTIVE_HIGH);
  endfunction

endpackage

// File: rtl/sm_key_debouncer_channel.sv
// One key channel: 2-flop synchroniser, polarity normalise, debounce counter,
// registered press/release strobes. Auto-repeat on held keys when
// SM_KEY_REPEAT_EN is defined.
module sm_key_channel
  import sm_key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ACTIVE_LOW      = 1
`ifdef SM_KEY_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_state,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic        IDLE = idle_level(ACTIVE_LOW);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_state;
  logic          r_press;
  logic          r_release;
  logic [CW-1:0] r_cnt;
  logic          w_s;
  logic          w_differ;
  logic          w_accept;
  logic          w_rep_fire;

  // Synchronise the asynchronous pin; reset loads the idle level so no edge is seen
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= IDLE;
      r_sync2 <= IDLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Normalised level and acceptance of a sustained difference
  always_comb begin
    w_s      = (ACTIVE_LOW != POL_ACTIVE_HIGH) ? ~r_sync2 : r_sync2;
    w_differ = (w_s != r_state);
    w_accept = w_differ && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  end

  // Debounce counter, accepted level and one-cycle strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= (w_accept && w_s) || w_rep_fire;
      r_release <= w_accept && !w_s;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_state <= w_s;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SM_KEY_REPEAT_EN
  localparam int unsigned RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  logic [RW-1:0] r_rcnt;
  rep_phase_e    r_phase;

  // Repeat fires on a held key, but never on the edge that accepts its release
  always_comb begin
    w_rep_fire = 1'b0;
    if (r_state && !w_accept) begin
      if (r_phase == REP_DELAY) begin
        w_rep_fire = (r_rcnt == RW'(REPEAT_DELAY - 1));
      end else begin
        w_rep_fire = (r_rcnt == RW'(REPEAT_PERIOD - 1));
      end
    end
  end

  // Repeat counter: first interval REPEAT_DELAY, then REPEAT_PERIOD
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rcnt  <= '0;
      r_phase <= REP_DELAY;
    end else if (!r_state || w_accept) begin
      r_rcnt  <= '0;
      r_phase <= REP_DELAY;
    end else if (w_rep_fire) begin
      r_rcnt  <= '0;
      r_phase <= REP_PERIOD;
    end else begin
      r_rcnt <= r_rcnt + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  assign o_state   = r_state;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/sm_key_debouncer.sv
// Board key conditioner: KEY_COUNT independent sm_key_channel instances.
// Optional auto-repeat of keyPress on held keys: define SM_KEY_REPEAT_EN.
module sm_key_debouncer
  import sm_key_debouncer_pkg::*;
#(
  parameter int unsigned KEY_COUNT       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                 clkIn,
  input  logic                 rst_n,
  input  logic [KEY_COUNT-1:0] keyRaw,
  output logic [KEY_COUNT-1:0] keyState,
  output logic [KEY_COUNT-1:0] keyPress,
  output logic [KEY_COUNT-1:0] keyRelease
);

  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
    sm_key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef SM_KEY_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_chan (
      .i_clk     (clkIn),
      .i_rst_n   (rst_n),
      .i_raw     (keyRaw[k]),
      .o_state   (keyState[k]),
      .o_press   (keyPress[k]),
      .o_release (keyRelease[k])
    );
  end

endmodule
